// File: rtl/pixel_rom_bank_pkg.sv
// ---------------------------------------------------------------------------
// pixel_rom_bank_pkg : colour constants, object type codes and helpers
//                      shared by the procedural pixel ROM bank.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pixel_rom_bank_pkg;

  localparam int PIX_W   = 12;
  localparam int COORD_W = 11;
  localparam int TYPE_W  = 3;

  localparam logic [PIX_W-1:0] TRANSPARENT = 12'h000;
  localparam logic [PIX_W-1:0] SKY_HAZE    = 12'h8CF;
  localparam logic [PIX_W-1:0] CLOUD       = 12'hEEF;
  localparam logic [PIX_W-1:0] COIN_RIM    = 12'hFD0;
  localparam logic [PIX_W-1:0] COIN_IN     = 12'hFA0;
  localparam logic [PIX_W-1:0] COIN_SHINE  = 12'hFF4;
  localparam logic [PIX_W-1:0] SHARK_BODY  = 12'h678;
  localparam logic [PIX_W-1:0] SHARK_BELLY = 12'hDDD;
  localparam logic [PIX_W-1:0] SHARK_EYE   = 12'h111;

  localparam logic [TYPE_W-1:0] TYPE_COIN  = 3'd0;
  localparam logic [TYPE_W-1:0] TYPE_SHARK = 3'd1;

  // Squared radii of the coin disc, in doubled coordinates
  localparam logic [31:0] COIN_OUTER_R2 = 32'd196;
  localparam logic [31:0] COIN_INNER_R2 = 32'd100;

  // Shark body ellipse: 36*(x-20)^2 + 361*(y-13)^2 <= 12996
  localparam logic [31:0] SHARK_CX     = 32'd20;
  localparam logic [31:0] SHARK_CY     = 32'd13;
  localparam logic [31:0] SHARK_KX     = 32'd36;
  localparam logic [31:0] SHARK_KY     = 32'd361;
  localparam logic [31:0] SHARK_LIMIT  = 32'd12996;
  localparam logic [31:0] SHARK_EYE_X  = 32'd33;
  localparam logic [31:0] SHARK_EYE_Y  = 32'd11;
  localparam logic [31:0] SHARK_BELLY_Y = 32'd14;

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    abs_diff = (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage : pixel_rom_bank_pkg

`default_nettype wire

// File: rtl/pixel_rom_bank_luts.sv
// ---------------------------------------------------------------------------
// sky_lut / coin_lut / shark_lut : combinational procedural pixel lookups.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sky_lut
  import pixel_rom_bank_pkg::*;
#(
  parameter int BG_WIDTH  = 1024,
  parameter int BG_HEIGHT = 512
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic [PIX_W-1:0]   o_pixel
);

  localparam int XW = $clog2(BG_WIDTH);

  logic [XW-1:0] w_xs;
  logic          w_cloud;
  logic [3:0]    w_red;
  logic [3:0]    w_green;
  logic          w_unused_x;

  assign w_xs       = i_x[XW-1:0];
  assign w_unused_x = &{1'b0, i_x[COORD_W-1:XW]};

  assign w_cloud = (i_y >= 11'd80) && (i_y < 11'd112) &&
                   (w_xs[7:0] >= 8'd32) && (w_xs[7:0] < 8'd128);

  // Vertical gradient: red steps every 128 rows, green every 64
  assign w_red   = 4'd4 + {2'b00, i_y[8:7]};
  assign w_green = 4'd8 + {1'b0, i_y[8:6]};

  always_comb begin
    o_pixel = SKY_HAZE;
    if ({21'd0, i_y} >= 32'(BG_HEIGHT)) begin
      o_pixel = SKY_HAZE;
    end else if (w_cloud) begin
      o_pixel = CLOUD;
    end else begin
      o_pixel = {w_red, w_green, 4'hF};
    end
  end

endmodule : sky_lut


module coin_lut
  import pixel_rom_bank_pkg::*;
#(
  parameter int COLL_WIDTH  = 15,
  parameter int COLL_HEIGHT = 16,
  parameter int LOG_FRAMES  = 3
) (
  input  logic [COORD_W-1:0]    i_x,
  input  logic [COORD_W-1:0]    i_y,
  input  logic [TYPE_W-1:0]     i_type,
  input  logic [LOG_FRAMES-1:0] i_frame,
  output logic [PIX_W-1:0]      o_pixel
);

  logic [31:0] w_x;
  logic [31:0] w_y;
  logic [31:0] w_dx;
  logic [31:0] w_dy;
  logic [31:0] w_dist2;
  logic        w_in_box;
  logic        w_unused_frame;

  assign w_x = {21'd0, i_x};
  assign w_y = {21'd0, i_y};

  assign w_in_box = (i_type == TYPE_COIN) &&
                    (w_x < 32'(COLL_WIDTH)) && (w_y < 32'(COLL_HEIGHT));

  // Doubled coordinates keep the half-pixel centre on an integer grid
  assign w_dx    = abs_diff(w_x << 1, 32'(COLL_WIDTH - 1));
  assign w_dy    = abs_diff(w_y << 1, 32'(COLL_HEIGHT - 1));
  assign w_dist2 = (w_dx * w_dx) + (w_dy * w_dy);

  assign w_unused_frame = &{1'b0, i_frame};

  always_comb begin
    o_pixel = TRANSPARENT;
    if (w_in_box) begin
      if (w_dist2 > COIN_OUTER_R2) begin
        o_pixel = TRANSPARENT;
      end else if (w_dist2 <= COIN_INNER_R2) begin
        o_pixel = i_frame[0] ? COIN_SHINE : COIN_IN;
      end else begin
        o_pixel = COIN_RIM;
      end
    end
  end

endmodule : coin_lut


module shark_lut
  import pixel_rom_bank_pkg::*;
#(
  parameter int SHARK_WIDTH  = 40,
  parameter int SHARK_HEIGHT = 20
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [TYPE_W-1:0]  i_type,
  output logic [PIX_W-1:0]   o_pixel
);

  logic [31:0] w_x;
  logic [31:0] w_y;
  logic [31:0] w_ax;
  logic [31:0] w_ay;
  logic [31:0] w_ellipse;
  logic        w_in_box;
  logic        w_eye;
  logic        w_body;
  logic        w_fin;

  assign w_x = {21'd0, i_x};
  assign w_y = {21'd0, i_y};

  assign w_in_box = (i_type == TYPE_SHARK) &&
                    (w_x < 32'(SHARK_WIDTH)) && (w_y < 32'(SHARK_HEIGHT));

  assign w_ax      = abs_diff(w_x, SHARK_CX);
  assign w_ay      = abs_diff(w_y, SHARK_CY);
  assign w_ellipse = (SHARK_KX * w_ax * w_ax) + (SHARK_KY * w_ay * w_ay);

  assign w_eye  = (w_x == SHARK_EYE_X) && (w_y == SHARK_EYE_Y);
  assign w_body = (w_ellipse <= SHARK_LIMIT);
  // Dorsal fin is a right triangle rising from the back
  assign w_fin  = (w_y >= 32'd1) && (w_y <= 32'd6) &&
                  (w_x >= 32'd18) && (w_x <= (32'd17 + w_y));

  always_comb begin
    o_pixel = TRANSPARENT;
    if (w_in_box) begin
      if (w_eye) begin
        o_pixel = SHARK_EYE;
      end else if (w_body) begin
        o_pixel = (w_y >= SHARK_BELLY_Y) ? SHARK_BELLY : SHARK_BODY;
      end else if (w_fin) begin
        o_pixel = SHARK_BODY;
      end
    end
  end

endmodule : shark_lut

`default_nettype wire

// File: rtl/pixel_rom_bank.sv
// ---------------------------------------------------------------------------
// pixel_rom_bank : sky, coin and shark pixel lookups with registered outputs.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pixel_rom_bank
  import pixel_rom_bank_pkg::*;
#(
  parameter int BG_WIDTH     = 1024,
  parameter int BG_HEIGHT    = 512,
  parameter int COLL_WIDTH   = 15,
  parameter int COLL_HEIGHT  = 16,
  parameter int SHARK_WIDTH  = 40,
  parameter int SHARK_HEIGHT = 20,
  parameter int LOG_FRAMES   = 3
) (
  input  logic                  vclock,
  input  logic                  reset,
  input  logic [COORD_W-1:0]    bg_x,
  input  logic [COORD_W-1:0]    bg_y,
  input  logic [COORD_W-1:0]    coll_x,
  input  logic [COORD_W-1:0]    coll_y,
  input  logic [TYPE_W-1:0]     coll_type,
  input  logic [LOG_FRAMES-1:0] coll_frame,
  output logic [PIX_W-1:0]      coll_pixel,
  input  logic [COORD_W-1:0]    shark_x,
  input  logic [COORD_W-1:0]    shark_y,
  input  logic [TYPE_W-1:0]     shark_type,
  input  logic [LOG_FRAMES-1:0] shark_frame,
  output logic [PIX_W-1:0]      shark_pixel,
  output logic [PIX_W-1:0]      bg_pixel
);

  logic [PIX_W-1:0] w_bg_pixel;
  logic [PIX_W-1:0] w_coll_pixel;
  logic [PIX_W-1:0] w_shark_pixel;
  logic [PIX_W-1:0] r_bg_pixel;
  logic [PIX_W-1:0] r_coll_pixel;
  logic [PIX_W-1:0] r_shark_pixel;
  logic             w_unused_shark_frame;

  // Shark art is a single static pose
  assign w_unused_shark_frame = &{1'b0, shark_frame};

  sky_lut #(
    .BG_WIDTH  (BG_WIDTH),
    .BG_HEIGHT (BG_HEIGHT)
  ) u_sky (
    .i_x     (bg_x),
    .i_y     (bg_y),
    .o_pixel (w_bg_pixel)
  );

  coin_lut #(
    .COLL_WIDTH  (COLL_WIDTH),
    .COLL_HEIGHT (COLL_HEIGHT),
    .LOG_FRAMES  (LOG_FRAMES)
  ) u_coin (
    .i_x     (coll_x),
    .i_y     (coll_y),
    .i_type  (coll_type),
    .i_frame (coll_frame),
    .o_pixel (w_coll_pixel)
  );

  shark_lut #(
    .SHARK_WIDTH  (SHARK_WIDTH),
    .SHARK_HEIGHT (SHARK_HEIGHT)
  ) u_shark (
    .i_x     (shark_x),
    .i_y     (shark_y),
    .i_type  (shark_type),
    .o_pixel (w_shark_pixel)
  );

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_bg_pixel    <= TRANSPARENT;
      r_coll_pixel  <= TRANSPARENT;
      r_shark_pixel <= TRANSPARENT;
    end else begin
      r_bg_pixel    <= w_bg_pixel;
      r_coll_pixel  <= w_coll_pixel;
      r_shark_pixel <= w_shark_pixel;
    end
  end

  assign bg_pixel    = r_bg_pixel;
  assign coll_pixel  = r_coll_pixel;
  assign shark_pixel = r_shark_pixel;

endmodule : pixel_rom_bank

`default_nettype wire

// File: tb/tb_pixel_rom_bank.sv
// ---------------------------------------------------------------------------
// tb_pixel_rom_bank : directed vectors with a queue-based scoreboard.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pixel_rom_bank;

  typedef struct packed {
    logic [11:0] bg;
    logic [11:0] coll;
    logic [11:0] shark;
  } exp_t;

  logic        vclock = 1'b0;
  logic        reset  = 1'b1;
  logic [10:0] bg_x = '0, bg_y = '0;
  logic [10:0] coll_x = '0, coll_y = '0;
  logic [2:0]  coll_type = 3'd1;
  logic [2:0]  coll_frame = '0;
  logic [10:0] shark_x = '0, shark_y = '0;
  logic [2:0]  shark_type = 3'd0;
  logic [2:0]  shark_frame = '0;
  logic [11:0] coll_pixel, shark_pixel, bg_pixel;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  pixel_rom_bank dut (
    .vclock      (vclock),
    .reset       (reset),
    .bg_x        (bg_x),
    .bg_y        (bg_y),
    .coll_x      (coll_x),
    .coll_y      (coll_y),
    .coll_type   (coll_type),
    .coll_frame  (coll_frame),
    .coll_pixel  (coll_pixel),
    .shark_x     (shark_x),
    .shark_y     (shark_y),
    .shark_type  (shark_type),
    .shark_frame (shark_frame),
    .shark_pixel (shark_pixel),
    .bg_pixel    (bg_pixel)
  );

  always #5 vclock = ~vclock;

  task automatic check(input string nm, input string ch, input logic [11:0] act, input logic [11:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s/%s: got %h expected %h", nm, ch, act, req);
  endtask

  // Monitor: output for each pushed vector appears just after the next edge
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge vclock);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, "bg",    bg_pixel,    e.bg);
        check(nm, "coll",  coll_pixel,  e.coll);
        check(nm, "shark", shark_pixel, e.shark);
      end
    end
  end

  task automatic vec(
    input logic        rst,
    input int bx, input int by,
    input int cx, input int cy, input int ct, input int cf,
    input int sx, input int sy, input int st,
    input logic [11:0] ebg, input logic [11:0] ecoll, input logic [11:0] eshark,
    input string nm);
    exp_t e;
    @(negedge vclock);
    reset       = rst;
    bg_x        = 11'(bx);
    bg_y        = 11'(by);
    coll_x      = 11'(cx);
    coll_y      = 11'(cy);
    coll_type   = 3'(ct);
    coll_frame  = 3'(cf);
    shark_x     = 11'(sx);
    shark_y     = 11'(sy);
    shark_type  = 3'(st);
    shark_frame = 3'(cf + 1);
    e.bg = ebg; e.coll = ecoll; e.shark = eshark;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    int budget;
    // Reset with arbitrary live inputs
    vec(1, 128, 90, 7, 7, 0, 0, 33, 11, 1, 12'h000, 12'h000, 12'h000, "reset0");
    vec(1, 32, 90, 1, 7, 0, 1, 20, 15, 1, 12'h000, 12'h000, 12'h000, "reset1");
    vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 12'h48F, 12'h000, 12'h000, "first");
    // Sky
    vec(0, 128, 90, 0, 0, 1, 0, 0, 0, 0, 12'h49F, 12'h000, 12'h000, "sky_grad");
    vec(0, 32, 90, 0, 0, 1, 0, 0, 0, 0, 12'hEEF, 12'h000, 12'h000, "sky_cloud");
    vec(0, 1056, 90, 0, 0, 1, 0, 0, 0, 0, 12'hEEF, 12'h000, 12'h000, "sky_wrap");
    vec(0, 0, 300, 0, 0, 1, 0, 0, 0, 0, 12'h6CF, 12'h000, 12'h000, "sky_row300");
    vec(0, 5, 600, 0, 0, 1, 0, 0, 0, 0, 12'h8CF, 12'h000, 12'h000, "sky_haze");
    // Coin
    vec(0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 12'h48F, 12'hFA0, 12'h000, "coin_in");
    vec(0, 0, 0, 7, 7, 0, 1, 0, 0, 0, 12'h48F, 12'hFF4, 12'h000, "coin_shine");
    vec(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 12'h48F, 12'hFD0, 12'h000, "coin_rim");
    vec(0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 12'h48F, 12'h000, 12'h000, "coin_edge");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h48F, 12'h000, 12'h000, "coin_corner");
    vec(0, 0, 0, 15, 7, 0, 0, 0, 0, 0, 12'h48F, 12'h000, 12'h000, "coin_xout");
    vec(0, 0, 0, 7, 7, 1, 0, 0, 0, 0, 12'h48F, 12'h000, 12'h000, "coin_type");
    // Shark
    vec(0, 0, 0, 0, 0, 1, 0, 33, 11, 1, 12'h48F, 12'h000, 12'h111, "shark_eye");
    vec(0, 0, 0, 0, 0, 1, 0, 20, 10, 1, 12'h48F, 12'h000, 12'h678, "shark_body");
    vec(0, 0, 0, 0, 0, 1, 0, 20, 15, 1, 12'h48F, 12'h000, 12'hDDD, "shark_belly");
    vec(0, 0, 0, 0, 0, 1, 0, 18, 1, 1, 12'h48F, 12'h000, 12'h678, "shark_fin");
    vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 12'h48F, 12'h000, 12'h000, "shark_corner");
    vec(0, 0, 0, 0, 0, 1, 0, 40, 10, 1, 12'h48F, 12'h000, 12'h000, "shark_xout");
    vec(0, 0, 0, 0, 0, 1, 0, 20, 10, 0, 12'h48F, 12'h000, 12'h000, "shark_type");
    // Stream with every channel changing each cycle
    vec(0, 32, 90, 7, 7, 0, 1, 20, 15, 1, 12'hEEF, 12'hFF4, 12'hDDD, "stream0");
    vec(0, 0, 300, 1, 7, 0, 0, 33, 11, 1, 12'h6CF, 12'hFD0, 12'h111, "stream1");
    vec(0, 5, 600, 7, 7, 0, 0, 18, 1, 1, 12'h8CF, 12'hFA0, 12'h678, "stream2");
    vec(1, 128, 90, 7, 7, 0, 0, 20, 10, 1, 12'h000, 12'h000, 12'h000, "midreset");
    vec(0, 128, 90, 0, 7, 0, 0, 20, 10, 1, 12'h49F, 12'h000, 12'h678, "stream3");
    vec(0, 1056, 90, 7, 7, 0, 1, 40, 10, 1, 12'hEEF, 12'hFF4, 12'h000, "stream4");

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge vclock);
      budget--;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pixel_rom_bank

`default_nettype wire

// File: doc/pixel_rom_bank.md
# pixel_rom_bank

Procedural pixel ROM bank for the surfing-game video pipeline. It answers three independent lookups per pixel clock: the scrolling sky background, the collectable coin sprite and the shark enemy sprite. Each lookup returns a 12-bit RGB pixel, with 12'h000 meaning transparent. It sits under the display compositor, which supplies sprite-relative coordinates and layers the returned pixels.

## Interface
- BG_WIDTH, 1024: sky width; x wraps modulo this (power of two)
- BG_HEIGHT, 512: sky height
- COLL_WIDTH / COLL_HEIGHT, 15 / 16: coin bounding box
- SHARK_WIDTH / SHARK_HEIGHT, 40 / 20: shark bounding box
- LOG_FRAMES, 3: frame-index width
- Reset is `reset`, synchronous, active-high; the clock is `vclock`.
- vclock  in  1  65 MHz pixel clock
- reset  in  1  synchronous active-high; zeroes all outputs
- bg_x, bg_y  in  11 each  sky coordinate; bg_x already includes the parallax offset
- coll_x, coll_y  in  11 each  coordinate relative to the coin origin
- coll_type  in  3  object identity
- coll_frame  in  LOG_FRAMES  animation frame
- coll_pixel  out  12  coin pixel
- shark_x, shark_y  in  11 each  coordinate relative to the shark origin
- shark_type  in  3  object identity
- shark_frame  in  LOG_FRAMES  animation frame; unused by content
- shark_pixel  out  12  shark pixel
- bg_pixel  out  12  sky pixel

## Operation
**Sky**
- Uses xs = bg_x[9:0] (wraps modulo 1024).
- If bg_y ≥ 512: 12'h8CF.
- Else, if 80 ≤ bg_y < 112 and 32 ≤ xs[7:0] < 128: cloud, 12'hEEF.
- Else: R = 4 + bg_y[8:7], G = 8 + bg_y[8:6], B = F. Example: row 0 gives 12'h48F.
- The sky output is never zero.

**Coin**
- Output is 0 if coll_type ≠ 0, or coll_x ≥ 15, or coll_y ≥ 16.
- Otherwise dx = |2·coll_x − 14|, dy = |2·coll_y − 15|, d = dx² + dy².
- d > 196: 0.
- d ≤ 100: inner colour, 12'hFA0 when coll_frame[0] = 0 and 12'hFF4 when coll_frame[0] = 1.
- Otherwise: rim, 12'hFD0.

**Shark**
- Output is 0 if shark_type ≠ 1, or shark_x ≥ 40, or shark_y ≥ 20.
- Eye at (33, 11): 12'h111.
- Body: 36·(x−20)² + 361·(y−13)² ≤ 12996. Colour is 12'hDDD when y ≥ 14, else 12'h678.
- Fin: 1 ≤ y ≤ 6 and 18 ≤ x ≤ 17+y gives 12'h678.
- Anything else: 0.

**Arithmetic and channels**
- All arithmetic is unsigned, at least 16 bits wide, with no truncation.
- The type gating guarantees the coin and shark ROMs are mutually exclusive for one object.
- The three channels are fully independent and are evaluated every cycle.

## Timing
- Each output is registered: pixel for the inputs sampled at edge N appears after edge N.
- Latency is 1 cycle, throughput is 1 pixel per cycle, and there is no handshake.
- With reset high at an edge, all outputs become 12'h000 and the inputs are ignored.
- The first valid pixel appears after the first edge with reset low.
- Reset mid-stream drops the in-flight pixel. There is no other state.

## Structure
- Shared package holds:
  - the colour constants (SKY_HAZE, CLOUD, COIN_RIM, COIN_IN, COIN_SHINE, SHARK_BODY, SHARK_BELLY, SHARK_EYE, TRANSPARENT);
  - the type codes (TYPE_COIN = 0, TYPE_SHARK = 1).
- Each lookup is a combinational sub-module: `sky_lut`, `coin_lut`, `shark_lut`.
- `pixel_rom_bank` instantiates the three sub-modules and owns the output registers and reset.

## Test plan
- Reset held for 2 cycles with arbitrary inputs -> all outputs 000. After release with bg (0,0) -> bg_pixel 48F one cycle later.
- Sky:
  - (x 128, y 90) -> 49F
  - (x 32, y 90) -> EEF
  - (x 1056, y 90) -> EEF (wrap)
  - (x 0, y 300) -> 6CF
  - (x 5, y 600) -> 8CF
- Coin, type 0:
  - (7,7) frame 0 -> FA0
  - (7,7) frame 1 -> FF4
  - (1,7) -> FD0
  - (0,7) -> 000
  - (0,0) -> 000
  - (15,7) -> 000
  - (7,7) with type 1 -> 000
- Shark, type 1:
  - (33,11) -> 111
  - (20,10) -> 678
  - (20,15) -> DDD
  - (18,1) -> 678
  - (0,0) -> 000
  - (40,10) -> 000
  - (20,10) with type 0 -> 000
- Back-to-back stream: change all inputs every cycle -> each output matches the previous cycle's inputs; the channels do not interfere.
